text_console_writer: RTL
========================

// Module: text_console_writer
// PURPOSE
// - Upstream feeder of video_memory's write port: turns an ASCII byte stream into cell writes.
// - Writes land in the 64x48 text screen rendered by the vga/text_rom path.
// - Keeps a cursor; handles CR, LF, BS, FF, line wrap and row wrap.
// - Blanks each newly entered row, so output reads as a rolling console.
// - Replaces hard-coded init sequencers: any source (UART, CPU, test pattern) streams chars in.
// PARAMETERS
// - COLS        64     characters per row; power of 2
// - ROWS        48     rows on screen; ROWS <= 2**ROW_W
// - COL_W        6     column index width; COLS == 2**COL_W
// - ROW_W        6     row index width
// - BLANK_CHAR  8'h20  code written when clearing cells
// PORTS
// - clk              in   1            system clock; all logic on posedge
// - reset_p          in   1            asynchronous, active-high reset
// - mem_reset_done   in   1            video_memory init finished; 0 = memory busy clearing
// - ch_data          in   8            ASCII byte
// - ch_valid         in   1            ch_data valid
// - ch_ready         out  1            byte accepted when ch_valid & ch_ready
// - w_addr           out  ROW_W+COL_W  video_memory write address {row, col}
// - w_data           out  8            video_memory write data
// - w_valid          out  1            write strobe, one cell per cycle
// - cursor_row       out  ROW_W        current cursor row
// - cursor_col       out  COL_W        current cursor column
// - busy             out  1            1 in any state other than IDLE
// BEHAVIOUR
// - Reset: state WAIT_MEM; cursor (0,0); ch_ready=0, w_valid=0, w_addr=0, w_data=0, busy=1.
// - All outputs registered.
// - WAIT_MEM: ch_ready=0. Goes to IDLE on the first cycle mem_reset_done=1.
// - mem_reset_done=0 in any state forces WAIT_MEM next cycle:
//   - the operation in flight is aborted;
//   - cursor returns to (0,0);
//   - w_valid drops.
// - IDLE: ch_ready=1. If a byte is accepted in cycle N:
//   - 0x20..0xFF: cycle N+1 gives w_valid=1, w_addr={row,col}, w_data=byte.
//     - If col<COLS-1: col+1, ch_ready stays 1. Throughput is 1 char/cycle.
//     - If col==COLS-1: col=0, row advances, then CLEAR_LINE.
//   - 0x0A LF: col=0, row advances, CLEAR_LINE runs cycles N+1..N+COLS.
//   - 0x0D CR: col=0, no write, ch_ready stays 1.
//   - 0x08 BS:
//     - col>0: col-1, and BLANK_CHAR is written at the new position in N+1.
//     - col==0: no-op; no reverse wrap to the previous row.
//   - 0x0C FF: CLEAR_SCREEN runs cycles N+1..N+ROWS*COLS, then cursor (0,0).
//   - Other codes < 0x20: accepted and dropped.
// - Row advance: row==ROWS-1 -> 0, else row+1. No scrolling; the memory is never read.
// - CLEAR_LINE: COLS consecutive writes of BLANK_CHAR to {row, 0..COLS-1}, ascending.
//   - ch_ready=0 from the first clear cycle through the last. IDLE follows.
// - Wrap timing: character write in N+1, row clear in N+2..N+COLS+1. ch_ready=0 in N+1..N+COLS+1.
// - CLEAR_SCREEN: addresses {0,0}..{ROWS-1,COLS-1}, ascending, one per cycle, ch_ready=0.
//   - Rows >= ROWS (3072..4095 at defaults) are never written.
// - Between writes, w_valid=0. w_addr and w_data hold their last value.
// - w_valid is never asserted in WAIT_MEM.
// - cursor_row/col always show the position of the next printable write.
// STRUCTURE
// - Package video_text_pkg holds:
//   - COLS, ROWS, COL_W, ROW_W, BLANK_CHAR;
//   - control-code constants CH_BS/LF/FF/CR;
//   - state enum {WAIT_MEM, IDLE, CLEAR_LINE, CLEAR_SCREEN}.
// - One sub-module, console_cursor, owns row/col registers.
//   - Commands: advance, newline, back, home.
//   - It handles both wraps.
// - The top-level FSM owns the write port and the clear counter (ROW_W+COL_W bits).
// TESTING
// - Hold mem_reset_done=0 for 20 cycles, then raise it
//   -> no w_valid before IDLE; ch_ready=1 one cycle after the rise.
// - Stream "AB" back-to-back from (0,0)
//   -> writes (0x000,0x41), (0x001,0x42) on consecutive cycles; cursor (0,2).
// - 64 'x' from (5,0)
//   -> 64 writes at 0x140..0x17F, then BLANK writes at 0x180..0x1BF; cursor (6,0); ch_ready back high.
// - Cursor (47,10), send LF
//   -> 64 BLANK writes at 0x000..0x03F; cursor (0,0).
// - Cursor (3,0) send BS -> no write.
//   Then 'Q','Z',BS -> writes 0x0C0='Q', 0x0C1='Z', 0x0C1=0x20; cursor (3,1).
// - Send FF, drop mem_reset_done at clear write #100
//   -> w_valid low next cycle; state WAIT_MEM; cursor (0,0).
//   Then raise it and send FF -> exactly 3072 writes, 0x000..0xBFF.

Source files
------------

// File: rtl/video_text_pkg.sv
// Shared geometry, control codes and FSM states for the text console writer.
// Geometry constants are derived here so both the cursor and the writer agree on wrap points.
package video_text_pkg;
  localparam int COLS   = 64;
  localparam int ROWS   = 48;
  localparam int COL_W  = 6;
  localparam int ROW_W  = 6;
  localparam int ADDR_W = ROW_W + COL_W;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  // Last visible cell; with COLS a power of two, {ROWS-1, COLS-1} == ROWS*COLS-1.
  localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(ROWS * COLS - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    WAIT_MEM,
    IDLE,
    CLEAR_LINE,
    CLEAR_SCREEN
  } state_t;
endpackage

// File: rtl/console_cursor.sv
// Cursor row/column registers with column and row wrap.
// Command priority: home > newline > advance > back > carriage.
module console_cursor
  import video_text_pkg::*;
(
  input  logic             clk,
  input  logic             reset_p,
  input  logic             advance,
  input  logic             newline,
  input  logic             back,
  input  logic             carriage,
  input  logic             home,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col
);
  logic [ROW_W-1:0] row_q, row_d, row_inc;
  logic [COL_W-1:0] col_q, col_d;

  always_comb begin
    row_inc = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
    row_d   = row_q;
    col_d   = col_q;
    if (home) begin
      row_d = '0;
      col_d = '0;
    end else if (newline) begin
      row_d = row_inc;
      col_d = '0;
    end else if (advance) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_inc;
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else if (back) begin
      // No reverse wrap into the previous row.
      if (col_q != '0) col_d = col_q - COL_W'(1);
    end else if (carriage) begin
      col_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;
endmodule

// File: rtl/text_console_writer.sv
// Turns an ASCII byte stream into video_memory cell writes, with line and screen clears.
// All outputs are registered; the FSM owns the write port and the clear counter.
module text_console_writer
  import video_text_pkg::*;
(
  input  logic              clk,
  input  logic              reset_p,
  input  logic              mem_reset_done,
  input  logic [7:0]        ch_data,
  input  logic              ch_valid,
  output logic              ch_ready,
  output logic [ADDR_W-1:0] w_addr,
  output logic [7:0]        w_data,
  output logic              w_valid,
  output logic [ROW_W-1:0]  cursor_row,
  output logic [COL_W-1:0]  cursor_col,
  output logic              busy
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]        w_data_q, w_data_d;
  logic              w_valid_q, w_valid_d;
  logic              ch_ready_q, ch_ready_d;
  logic              busy_q, busy_d;
  logic              cur_advance, cur_newline, cur_back, cur_carriage, cur_home;
  logic [COL_W-1:0]  col_m1;
  logic              accept;

  console_cursor u_cursor (
    .clk      (clk),
    .reset_p  (reset_p),
    .advance  (cur_advance),
    .newline  (cur_newline),
    .back     (cur_back),
    .carriage (cur_carriage),
    .home     (cur_home),
    .row      (cursor_row),
    .col      (cursor_col)
  );

  assign col_m1 = cursor_col - COL_W'(1);
  assign accept = ch_valid & ch_ready_q & (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    w_addr_d     = w_addr_q;
    w_data_d     = w_data_q;
    w_valid_d    = 1'b0;
    ch_ready_d   = ch_ready_q;
    cur_advance  = 1'b0;
    cur_newline  = 1'b0;
    cur_back     = 1'b0;
    cur_carriage = 1'b0;
    cur_home     = 1'b0;

    unique case (state_q)
      WAIT_MEM: begin
        ch_ready_d = 1'b0;
        if (mem_reset_done) begin
          state_d    = IDLE;
          ch_ready_d = 1'b1;
        end
      end
      IDLE: begin
        ch_ready_d = 1'b1;
        if (accept) begin
          if (ch_data >= 8'h20) begin
            w_valid_d   = 1'b1;
            w_addr_d    = {cursor_row, cursor_col};
            w_data_d    = ch_data;
            cur_advance = 1'b1;
            if (cursor_col == COL_LAST) begin
              state_d    = CLEAR_LINE;
              cnt_d      = '0;
              ch_ready_d = 1'b0;
            end
          end else begin
            case (ch_data)
              CH_LF: begin
                cur_newline = 1'b1;
                state_d     = CLEAR_LINE;
                cnt_d       = '0;
                ch_ready_d  = 1'b0;
              end
              CH_CR: cur_carriage = 1'b1;
              CH_BS: begin
                if (cursor_col != '0) begin
                  cur_back  = 1'b1;
                  w_valid_d = 1'b1;
                  w_addr_d  = {cursor_row, col_m1};
                  w_data_d  = BLANK_CHAR;
                end
              end
              CH_FF: begin
                cur_home   = 1'b1;
                state_d    = CLEAR_SCREEN;
                cnt_d      = '0;
                ch_ready_d = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end
      CLEAR_LINE: begin
        // Cursor already sits on the new row, so it supplies the row half of the address.
        ch_ready_d = 1'b0;
        w_valid_d  = 1'b1;
        w_addr_d   = {cursor_row, cnt_q[COL_W-1:0]};
        w_data_d   = BLANK_CHAR;
        cnt_d      = cnt_q + ADDR_W'(1);
        if (cnt_q[COL_W-1:0] == COL_LAST) state_d = IDLE;
      end
      CLEAR_SCREEN: begin
        ch_ready_d = 1'b0;
        w_valid_d  = 1'b1;
        w_addr_d   = cnt_q;
        w_data_d   = BLANK_CHAR;
        cnt_d      = cnt_q + ADDR_W'(1);
        if (cnt_q == CELL_LAST) state_d = IDLE;
      end
      default: state_d = WAIT_MEM;
    endcase

    // Memory going busy aborts whatever is in flight.
    if (!mem_reset_done) begin
      state_d    = WAIT_MEM;
      w_valid_d  = 1'b0;
      ch_ready_d = 1'b0;
      cur_home   = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q    <= WAIT_MEM;
      cnt_q      <= '0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      w_valid_q  <= 1'b0;
      ch_ready_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      w_valid_q  <= w_valid_d;
      ch_ready_q <= ch_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign ch_ready = ch_ready_q;
  assign w_addr   = w_addr_q;
  assign w_data   = w_data_q;
  assign w_valid  = w_valid_q;
  assign busy     = busy_q;
endmodule
